// File: rtl/ram_dma_ci_engine.sv
// Scratchpad RAM custom instruction with a background copy/fill engine.
// Port A serves CPU reads/writes; port B belongs to the engine.
module ram_dma_ci_engine #(
    parameter logic [7:0] customId  = 8'd14,
    parameter int         addrWidth = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);
    localparam int depth = 2 ** addrWidth;

    localparam logic [2:0] OP_READ   = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_SRC    = 3'd2;
    localparam logic [2:0] OP_DST    = 3'd3;
    localparam logic [2:0] OP_LEN    = 3'd4;
    localparam logic [2:0] OP_COPY   = 3'd5;
    localparam logic [2:0] OP_FILL   = 3'd6;
    localparam logic [2:0] OP_STATUS = 3'd7;

    localparam logic [addrWidth:0]   lenMax  = {1'b1, {addrWidth{1'b0}}};
    localparam logic [addrWidth:0]   lenOne  = {{addrWidth{1'b0}}, 1'b1};
    localparam logic [addrWidth-1:0] addrOne = {{(addrWidth-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, COPY_RD, COPY_WR, FILL} engState_t;

    // Lengths beyond the whole scratchpad clamp to one full pass.
    function automatic logic [addrWidth:0] satLen(input logic [31:0] raw);
        if (raw > {{(31 - addrWidth){1'b0}}, lenMax}) return lenMax;
        return raw[addrWidth:0];
    endfunction

    logic [31:0] mem [depth];

    engState_t            state, nextState;
    logic [addrWidth-1:0] srcReg, dstReg, engSrc, engDst;
    logic [addrWidth:0]   lenReg, remaining;
    logic [31:0]          readData, copyData, fillPattern, engData;
    logic                 readPending, busy, engWrite;

    logic [2:0]           opcode;
    logic [addrWidth-1:0] ciAddr;
    logic                 validReq, readIssue, ciWrite, startReq, startAccept;
    logic                 unusedA;

    assign opcode      = valueA[31:29];
    assign ciAddr      = valueA[addrWidth-1:0];
    assign unusedA     = ^valueA[28:addrWidth];
    assign validReq    = start && (ciN == customId) && !reset;
    assign readIssue   = validReq && (opcode == OP_READ) && !readPending;
    assign ciWrite     = validReq && (opcode == OP_WRITE);
    assign startReq    = validReq && ((opcode == OP_COPY) || (opcode == OP_FILL));
    assign busy        = (state != IDLE);
    assign startAccept = startReq && !busy;

    always_comb begin
        nextState = state;
        engWrite  = 1'b0;
        engData   = copyData;
        case (state)
            IDLE: begin
                if (startAccept && (lenReg != '0))
                    nextState = (opcode == OP_COPY) ? COPY_RD : FILL;
            end
            COPY_RD: nextState = COPY_WR;
            COPY_WR: begin
                engWrite  = 1'b1;
                nextState = (remaining > lenOne) ? COPY_RD : IDLE;
            end
            FILL: begin
                engWrite  = 1'b1;
                engData   = fillPattern;
                nextState = (remaining > lenOne) ? FILL : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            readPending <= 1'b0;
            srcReg      <= '0;
            dstReg      <= '0;
            lenReg      <= '0;
            engSrc      <= '0;
            engDst      <= '0;
            remaining   <= '0;
        end else begin
            state       <= nextState;
            readPending <= readIssue;
            if (validReq && opcode == OP_SRC) srcReg <= ciAddr;
            if (validReq && opcode == OP_DST) dstReg <= ciAddr;
            if (validReq && opcode == OP_LEN) lenReg <= satLen(valueB);
            // Shadow registers are copied into the working set only on acceptance.
            if (startAccept) begin
                engSrc    <= srcReg;
                engDst    <= dstReg;
                remaining <= lenReg;
            end else if (engWrite) begin
                engDst    <= engDst + addrOne;
                remaining <= remaining - lenOne;
            end
            if (state == COPY_RD) engSrc <= engSrc + addrOne;
        end
    end

    // Memory is never cleared by reset; CI write is issued last so it wins a collision.
    always_ff @(posedge clock) begin
        if (readIssue) readData <= mem[ciAddr];
        if (state == COPY_RD) copyData <= mem[engSrc];
        if (startAccept) fillPattern <= valueB;
        if (engWrite && !(ciWrite && (ciAddr == engDst))) mem[engDst] <= engData;
        if (ciWrite) mem[ciAddr] <= valueB;
    end

    always_comb begin
        done   = 1'b0;
        result = '0;
        if (readPending) begin
            done   = 1'b1;
            result = readData;
        end else if (validReq && (opcode != OP_READ)) begin
            done = 1'b1;
            case (opcode)
                OP_COPY, OP_FILL: result = {31'd0, busy};
                OP_STATUS:        result = {busy, {(30 - addrWidth){1'b0}}, remaining};
                default:          result = '0;
            endcase
        end
    end
endmodule

// File: doc/ram_dma_ci_engine.md
RAM_DMA_CI_ENGINE -- requirements
Module: ram_dma_ci_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter SHALL be customId, 8'd14, custom-instruction number the block answers to.
REQ-003 Parameter SHALL be addrWidth, 9, scratchpad word address width; depth = 2**addrWidth words of 32 bits.
REQ-004 Port SHALL be clock  input  1  rising-edge clock.
REQ-005 Port SHALL be reset  input  1  asynchronous active-high reset.
REQ-006 Port SHALL be start  input  1  CI request strobe.
REQ-007 Port SHALL be ciN  input  8  CI number; request is valid only when start=1 and ciN==customId.
REQ-008 Port SHALL be valueA  input  32  [31:29] opcode, [addrWidth-1:0] address.
REQ-009 Port SHALL be valueB  input  32  write data / length / fill pattern.
REQ-010 Port SHALL be done  output  1  CI completion.
REQ-011 Port SHALL be result  output  32  CI result; 0 whenever done=0.

Function
REQ-012 Memory SHALL be dual-ported: port A serves CI, port B serves the copy/fill engine.
REQ-013 Opcode 0 READ SHALL assert done exactly 1 cycle after the valid request, with result=mem[addr]; the request inputs are held by the CPU until done.
REQ-014 Opcode 1 WRITE SHALL write valueB to mem[addr] on the request edge, with done in the same cycle (combinational) and result=0.
REQ-015 Opcodes 2 SET_SRC and 3 SET_DST SHALL load the src/dst register from addr; opcode 4 SET_LEN SHALL load len=valueB[addrWidth:0]; done in the same cycle, result=0.
REQ-016 Opcode 5 START_COPY SHALL copy mem[src+i] to mem[dst+i] for i=0..len-1; opcode 6 START_FILL SHALL write valueB to mem[dst+i]; done in the same cycle.
REQ-017 A start opcode SHALL return result=0 when accepted and result=1 when rejected because the engine is busy; a rejected start changes no state.
REQ-018 Opcode 7 STATUS SHALL return result={busy, zeros, remaining[addrWidth:0]} with busy in bit 31, done in the same cycle.
REQ-019 SET_SRC/SET_DST/SET_LEN issued while busy SHALL update the shadow registers only; the running transfer uses the values latched at start.
REQ-020 Engine FSM states SHALL be IDLE, COPY_RD, COPY_WR, FILL.
REQ-021 Transitions: IDLE->COPY_RD on accepted copy with len>0; IDLE->FILL on accepted fill with len>0; COPY_RD->COPY_WR always; COPY_WR->COPY_RD when remaining>1 else IDLE; FILL stays while remaining>1 else IDLE.
REQ-022 Copy SHALL take 2 cycles per word; fill SHALL take 1 cycle per word.
REQ-023 A start with len=0 SHALL be accepted, keep busy=0 and write nothing.
REQ-024 Address increments SHALL wrap modulo depth (e.g. dst=2**addrWidth-1 then 0).
REQ-025 len SHALL saturate at depth: values above 2**addrWidth are loaded as 2**addrWidth.
REQ-026 The busy flag SHALL be 1 from the cycle after acceptance until the cycle after the last engine write.
REQ-027 When a CI WRITE and an engine write target the same address in the same cycle, the CI write SHALL win and the engine write SHALL be discarded; the engine SHALL still advance.
REQ-028 A CI READ of an address the engine writes in the same cycle SHALL return the old data.
REQ-029 Invalid requests (start=0 or ciN!=customId) SHALL produce done=0 and result=0, with no state change.

Reset
REQ-030 Reset SHALL force done=0, result=0, state=IDLE, busy=0, and src=dst=len=remaining=0 immediately, independent of clock.
REQ-031 Reset mid-transfer SHALL abort the transfer; words already written SHALL remain and memory contents SHALL NOT be cleared.
REQ-032 A READ pending across reset SHALL NOT produce done after reset is released.

Verification
REQ-033 Invalid request (start=1, ciN=7, WRITE) -> done=0, result=0, and a subsequent READ shows the memory unchanged.
REQ-034 WRITE addr 5 value 0xDEADBEEF, then READ addr 5 -> done=0 in the request cycle, done=1 with result=0xDEADBEEF one cycle later.
REQ-035 Fill dst=510, len=4, pattern 0xA5A5A5A5 -> result=0; busy for 4 cycles; words 510, 511, 0, 1 = 0xA5A5A5A5; word 2 is untouched.
REQ-036 Copy src=0, dst=100, len=3, then STATUS each cycle -> remaining counts 3,2,1,0 over 6 cycles; mem[100..102]=mem[0..2]; a second START_COPY while busy returns result=1.
REQ-037 During a fill of addr 20..29, a CI WRITE to addr 24 in the same cycle the engine writes 24 -> mem[24] holds the CI data.
REQ-038 Reset asserted mid-copy (after 2 words, len=8) -> done=0, busy=0 immediately; dst+0 and dst+1 updated, dst+2..7 unchanged.
